alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-compare unit.
- Arbitrates round-robin and drives the ALU operands and select from registers.
- Captures result and zero flag, and returns them to the winning requester over a valid/ready response channel.
- One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width
- SEL_W, 4, ALU select width; the select code is passed through to the ALU opaquely

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  reset, asynchronous, active-low
- req0Valid  in  1  requester 0 has an operation
- req0Ready  out  1  requester 0 operation accepted this cycle
- req0A  in  WIDTH  requester 0 operand A
- req0B  in  WIDTH  requester 0 operand B
- req0Sel  in  SEL_W  requester 0 ALU select
- rsp0Valid  out  1  result available for requester 0
- rsp0Ready  in  1  requester 0 takes result
- rsp0Result  out  WIDTH  result for requester 0
- rsp0Zero  out  1  zero flag for requester 0
- req1Valid, req1Ready, req1A, req1B, req1Sel, rsp1Valid, rsp1Ready, rsp1Result, rsp1Zero  same as above for requester 1
- aluA  out  WIDTH  to ALU inputA
- aluB  out  WIDTH  to ALU inputB
- aluSel  out  SEL_W  to ALU aluSel
- aluResult  in  WIDTH  from ALU result
- aluZero  in  1  from ALU zero
- busy  out  1  state != IDLE
- grantId  out  1  owner of the current/last transaction

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values (applied asynchronously on rstN low):
  - all outputs 0
  - operand/result registers 0
  - lastGrant=1, so requester 0 wins first
- IDLE:
  - Winner: sole valid requester; if both valid, the requester != lastGrant.
  - reqNReady=1 combinationally for the winner only. It may depend on reqNValid; reqNValid must not depend on reqNReady.
  - On valid&&ready:
    - latch A/B/Sel into aluA/aluB/aluSel registers
    - set grantId=winner and lastGrant=winner
    - go to EXEC
- EXEC (exactly 1 cycle):
  - aluA/aluB/aluSel are stable from the registers; the ALU settles combinationally.
  - At the clock edge, capture aluResult/aluZero into the owner's rspResult/rspZero and go to RESP.
- RESP:
  - rspNValid=1 for the owner only; result and zero are held stable.
  - On rspNValid&&rspNReady, go to IDLE and clear rspNValid. No new accept occurs in the same cycle.
- All reqReady are 0 outside IDLE.
- Latency: accept at cycle T; rspValid asserted at T+2; minimum issue interval is 3 cycles.
- Non-owner rspValid stays 0. rspReady while rspValid=0 is ignored.
- aluA/aluB/aluSel/grantId hold their last values after a transaction. rspResult/rspZero hold until the next capture for that port.
- Unbounded backpressure in RESP is legal: the block stalls, and busy stays 1.
- Requester valid dropping before accept is legal; nothing is latched.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response. After release the block is in IDLE with lastGrant=1.
- Widths: result and operands are WIDTH bits, with no extension or truncation by this block.

Test Plan:
1. req0 only, A=5 B=7, Sel=add code, bench ALU model -> req0Ready=1 at T; aluA=5, aluB=7 at T+1; rsp0Valid=1, rsp0Result=12, rsp0Zero=0 at T+2; rsp1Valid=0 throughout.
2. Both valid continuously from reset, rsp ready held 1 -> grant order 0,1,0,1; each rsp arrives on the matching port; grantId tracks the order.
3. req0 op, rsp0Ready held low 4 cycles -> rsp0Valid and rsp0Result stable for 4 cycles; req1Valid=1 but req1Ready=0 throughout; busy=1; req1 granted in the cycle after the rsp0 handshake (IDLE).
4. req1 A=3 B=3, Sel=sub code -> rsp1Result=0, rsp1Zero=1. Then A=3 B=1 -> rsp1Result=2, rsp1Zero=0.
5. rstN pulled low during EXEC (mid-cycle) -> all outputs 0 immediately without a clock edge; after release no rspValid appears; with both requesters valid, requester 0 is granted first.
6. req1 only, back-to-back ops -> req1 is granted each time despite lastGrant=1; issue interval is exactly 3 cycles with rsp1Ready=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters,
// with registered operands and a valid/ready result return to the winner.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             req0Valid,
    output logic             req0Ready,
    input  logic [WIDTH-1:0] req0A,
    input  logic [WIDTH-1:0] req0B,
    input  logic [SEL_W-1:0] req0Sel,
    output logic             rsp0Valid,
    input  logic             rsp0Ready,
    output logic [WIDTH-1:0] rsp0Result,
    output logic             rsp0Zero,
    input  logic             req1Valid,
    output logic             req1Ready,
    input  logic [WIDTH-1:0] req1A,
    input  logic [WIDTH-1:0] req1B,
    input  logic [SEL_W-1:0] req1Sel,
    output logic             rsp1Valid,
    input  logic             rsp1Ready,
    output logic [WIDTH-1:0] rsp1Result,
    output logic             rsp1Zero,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    output logic [SEL_W-1:0] aluSel,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluZero,
    output logic             busy,
    output logic             grantId
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d, grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res0_q, res0_d, res1_q, res1_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             zero0_q, zero0_d, zero1_q, zero1_d;
    logic             win, accept, rsp_hs, cap0, cap1;

    always_comb begin
        // win=1 means requester 1 wins: it is alone, or it is not the last grantee
        win     = req1Valid & (~req0Valid | ~last_q);
        accept  = (state_q == IDLE) & (req0Valid | req1Valid);
        rsp_hs  = (state_q == RESP) & (grant_q ? rsp1Ready : rsp0Ready);
        state_d = accept ? EXEC : (state_q == EXEC) ? RESP : rsp_hs ? IDLE : state_q;
        last_d  = accept ? win : last_q;
        grant_d = accept ? win : grant_q;
        a_d     = accept ? (win ? req1A : req0A) : a_q;
        b_d     = accept ? (win ? req1B : req0B) : b_q;
        sel_d   = accept ? (win ? req1Sel : req0Sel) : sel_q;
        cap0    = (state_q == EXEC) & ~grant_q;
        cap1    = (state_q == EXEC) & grant_q;
        res0_d  = cap0 ? aluResult : res0_q;
        zero0_d = cap0 ? aluZero : zero0_q;
        res1_d  = cap1 ? aluResult : res1_q;
        zero1_d = cap1 ? aluZero : zero1_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res0_q  <= '0;
            zero0_q <= 1'b0;
            res1_q  <= '0;
            zero1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res0_q  <= res0_d;
            zero0_q <= zero0_d;
            res1_q  <= res1_d;
            zero1_q <= zero1_d;
        end
    end

    // ready is masked by reset so every output reads 0 while rstN is low
    assign req0Ready  = rstN & (state_q == IDLE) & req0Valid & ~win;
    assign req1Ready  = rstN & (state_q == IDLE) & win;
    assign rsp0Valid  = (state_q == RESP) & ~grant_q;
    assign rsp1Valid  = (state_q == RESP) & grant_q;
    assign rsp0Result = res0_q;
    assign rsp0Zero   = zero0_q;
    assign rsp1Result = res1_q;
    assign rsp1Zero   = zero1_q;
    assign aluA       = a_q;
    assign aluB       = b_q;
    assign aluSel     = sel_q;
    assign busy       = (state_q != IDLE);
    assign grantId    = grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed tests against a transaction-level model of the arbiter,
// checked every cycle, plus hand-computed literal expectations.
module tb_alu_share_arbiter;
    logic        clk = 0, rstN = 0;
    logic        req0Valid = 0, req1Valid = 0, rsp0Ready = 1, rsp1Ready = 1;
    logic [31:0] req0A = 0, req0B = 0, req1A = 0, req1B = 0;
    logic [3:0]  req0Sel = 0, req1Sel = 0;
    logic        req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0Zero, rsp1Zero;
    logic [31:0] rsp0Result, rsp1Result, aluA, aluB, aluResult;
    logic [3:0]  aluSel;
    logic        aluZero, busy, grantId;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
        .clk(clk), .rstN(rstN),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0A(req0A), .req0B(req0B), .req0Sel(req0Sel),
        .rsp0Valid(rsp0Valid), .rsp0Ready(rsp0Ready), .rsp0Result(rsp0Result), .rsp0Zero(rsp0Zero),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1A(req1A), .req1B(req1B), .req1Sel(req1Sel),
        .rsp1Valid(rsp1Valid), .rsp1Ready(rsp1Ready), .rsp1Result(rsp1Result), .rsp1Zero(rsp1Zero),
        .aluA(aluA), .aluB(aluB), .aluSel(aluSel), .aluResult(aluResult), .aluZero(aluZero),
        .busy(busy), .grantId(grantId)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign aluResult = alu_fn(aluA, aluB, aluSel);
    assign aluZero   = (aluResult == 32'd0);

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Transaction model: one pending op with its age in cycles since acceptance.
    logic        m_pend = 0, m_owner = 0, m_last = 1, m_grant = 0;
    int          m_age = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [3:0]  m_sel = 0;
    logic [31:0] m_res [2] = '{0, 0};
    logic        m_zero [2] = '{0, 0};

    function automatic logic m_winner();
        return (req0Valid && req1Valid) ? !m_last : req1Valid;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_pend <= 0; m_owner <= 0; m_last <= 1; m_grant <= 0; m_age <= 0;
            m_a <= 0; m_b <= 0; m_sel <= 0;
            m_res[0] <= 0; m_res[1] <= 0; m_zero[0] <= 0; m_zero[1] <= 0;
        end else if (!m_pend) begin
            if (req0Valid || req1Valid) begin
                m_pend <= 1; m_age <= 1;
                m_owner <= m_winner(); m_last <= m_winner(); m_grant <= m_winner();
                m_a <= m_winner() ? req1A : req0A;
                m_b <= m_winner() ? req1B : req0B;
                m_sel <= m_winner() ? req1Sel : req0Sel;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
            m_res[m_owner] <= alu_fn(m_a, m_b, m_sel);
            m_zero[m_owner] <= (alu_fn(m_a, m_b, m_sel) == 32'd0);
        end else if (m_owner ? rsp1Ready : rsp0Ready) begin
            m_pend <= 0;
        end
    end

    always @(negedge clk) begin
        chk("req0Ready", req0Ready, rstN && !m_pend && req0Valid && !m_winner());
        chk("req1Ready", req1Ready, rstN && !m_pend && req1Valid && m_winner());
        chk("rsp0Valid", rsp0Valid, m_pend && m_age >= 2 && !m_owner);
        chk("rsp1Valid", rsp1Valid, m_pend && m_age >= 2 && m_owner);
        chk("rsp0Result", rsp0Result, m_res[0]);
        chk("rsp0Zero", rsp0Zero, m_zero[0]);
        chk("rsp1Result", rsp1Result, m_res[1]);
        chk("rsp1Zero", rsp1Zero, m_zero[1]);
        chk("aluA", aluA, m_a);
        chk("aluB", aluB, m_b);
        chk("aluSel", aluSel, m_sel);
        chk("busy", busy, m_pend);
        chk("grantId", grantId, m_grant);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 0;
        step(2);
        rstN = 1;
        step(1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin step(1); n++; end
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    task automatic do_op(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                         output logic [31:0] r, output logic z);
        int n = 0;
        if (p) begin req1A = a; req1B = b; req1Sel = s; req1Valid = 1; end
        else   begin req0A = a; req0B = b; req0Sel = s; req0Valid = 1; end
        #1;
        while (!(p ? req1Ready : req0Ready) && n < 20) begin step(1); n++; end
        chk("op_ready", p ? req1Ready : req0Ready, 1);
        step(1);
        req0Valid = 0; req1Valid = 0;
        step(1);
        chk("op_rspValid", p ? rsp1Valid : rsp0Valid, 1);
        r = p ? rsp1Result : rsp0Result;
        z = p ? rsp1Zero : rsp0Zero;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic        z;
        int          g [$];
        int          gi [$];
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_aluA", aluA, 0);
        chk("rst_grantId", grantId, 0);
        rstN = 1;
        step(1);

        // Test 1: req0 alone, 5+7
        req0A = 5; req0B = 7; req0Sel = 0; req0Valid = 1;
        #1 chk("t1_ready0", req0Ready, 1);
        step(1);
        req0Valid = 0;
        chk("t1_aluA", aluA, 5);
        chk("t1_aluB", aluB, 7);
        chk("t1_rsp1Valid_exec", rsp1Valid, 0);
        step(1);
        chk("t1_rsp0Valid", rsp0Valid, 1);
        chk("t1_rsp0Result", rsp0Result, 12);
        chk("t1_rsp0Zero", rsp0Zero, 0);
        chk("t1_rsp1Valid", rsp1Valid, 0);
        step(1);

        // Test 2: both valid from reset, grants alternate 0,1,0,1
        do_reset();
        req0A = 10; req0B = 20; req0Sel = 0;
        req1A = 50; req1B = 8;  req1Sel = 1;
        req0Valid = 1; req1Valid = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0Ready) g.push_back(0);
            if (req1Ready) g.push_back(1);
            @(posedge clk); #1;
        end
        req0Valid = 0; req1Valid = 0;
        chk("t2_ngrants", g.size(), 4);
        for (int i = 0; i < g.size() && i < 4; i++) chk("t2_order", g[i], i % 2);
        chk("t2_rsp0Result", rsp0Result, 30);
        chk("t2_rsp1Result", rsp1Result, 42);
        wait_idle();

        // Test 3: rsp0 backpressure with req1 waiting
        rsp0Ready = 0;
        req0A = 100; req0B = 23; req0Sel = 0; req0Valid = 1;
        req1A = 3; req1B = 3; req1Sel = 1; req1Valid = 1;
        #1 chk("t3_ready0", req0Ready, 1);
        chk("t3_ready1", req1Ready, 0);
        step(1);
        req0Valid = 0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rsp0Valid", rsp0Valid, 1);
            chk("t3_rsp0Result", rsp0Result, 123);
            chk("t3_req1Ready", req1Ready, 0);
            chk("t3_busy", busy, 1);
            step(1);
        end
        rsp0Ready = 1;
        step(1);
        chk("t3_req1_granted", req1Ready, 1);
        chk("t3_busy_idle", busy, 0);

        // Test 4: 3-3 -> zero, then 3-1 -> 2
        step(1);
        req1Valid = 0;
        chk("t4_grantId", grantId, 1);
        step(1);
        chk("t4a_rsp1Valid", rsp1Valid, 1);
        chk("t4a_result", rsp1Result, 0);
        chk("t4a_zero", rsp1Zero, 1);
        step(1);
        do_op(1, 3, 1, 1, r, z);
        chk("t4b_result", r, 2);
        chk("t4b_zero", z, 0);

        // Test 5: async reset during EXEC
        req0A = 9; req0B = 9; req0Sel = 0; req0Valid = 1;
        step(1);
        req1Valid = 1;
        chk("t5_in_exec", busy, 1);
        #2 rstN = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_aluA", aluA, 0);
        chk("t5_aluB", aluB, 0);
        chk("t5_aluSel", aluSel, 0);
        chk("t5_grantId", grantId, 0);
        chk("t5_ready0", req0Ready, 0);
        chk("t5_ready1", req1Ready, 0);
        chk("t5_rsp0Result", rsp0Result, 0);
        chk("t5_rsp1Result", rsp1Result, 0);
        chk("t5_rsp0Valid", rsp0Valid, 0);
        step(2);
        req0Valid = 0; req1Valid = 0;
        rstN = 1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t5_norsp0", rsp0Valid, 0);
            chk("t5_norsp1", rsp1Valid, 0);
        end
        req0Valid = 1; req1Valid = 1;
        #1 chk("t5_first0", req0Ready, 1);
        chk("t5_first1", req1Ready, 0);
        step(1);
        req0Valid = 0; req1Valid = 0;
        step(1);
        chk("t5_rsp0Result", rsp0Result, 18);
        step(1);

        // Test 6: req1 alone back-to-back, interval 3
        do_reset();
        req1A = 7; req1B = 2; req1Sel = 3; req1Valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req1Ready) gi.push_back(i);
            @(posedge clk); #1;
        end
        req1Valid = 0;
        chk("t6_ngrants", gi.size(), 4);
        for (int i = 1; i < gi.size(); i++) chk("t6_interval", gi[i] - gi[i-1], 3);
        chk("t6_result", rsp1Result, 7);
        wait_idle();
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
